// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts byte-PC fetch requests and returns the
// instruction word after LATENCY cycles over a valid/ready handshake.
module imem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  flush,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_instr,
  output logic [ADDR_WIDTH-1:0] rsp_pc,
  output logic                  rsp_fault,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [31:0]           load_data
);

  localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int WIDX_W = ADDR_WIDTH - 2;
  // One extra bit so a power-of-two depth equal to the full index span still compares correctly.
  localparam logic [WIDX_W:0] DEPTH_LIM = (WIDX_W + 1)'(DEPTH_WORDS);
  localparam logic [3:0]      WAIT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [31:0]       instr_reg;
  logic              fault_reg;
  logic              accept;
  logic              handshake;

  logic [WIDX_W-1:0] req_widx;
  logic [WIDX_W-1:0] load_widx;
  logic              req_fault;
  logic              load_fault;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_widx   = req_addr[ADDR_WIDTH-1:2];
  assign load_widx  = load_addr[ADDR_WIDTH-1:2];
  assign req_fault  = (req_addr[1:0] != 2'b00) || ({1'b0, req_widx} >= DEPTH_LIM);
  assign load_fault = (load_addr[1:0] != 2'b00) || ({1'b0, load_widx} >= DEPTH_LIM);

  // Faulting load writes are dropped rather than wrapped into the array.
  always_ff @(posedge clk) begin
    if (load_en && !load_fault) begin
      mem[load_widx[IDX_W-1:0]] <= load_data;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = ~flush;
      end
      WAIT: begin
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready & ~flush;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    req_ready = req_ready & rst_n;
    accept    = req_valid & req_ready;
    handshake = rsp_valid & rsp_ready;
    // A new acceptance overrides the plain return to IDLE after a handshake.
    if (accept) begin
      state_next = (LATENCY == 1) ? RESP : WAIT;
      cnt_next   = WAIT_INIT;
    end
    if (flush) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      pc_reg    <= '0;
      instr_reg <= '0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        pc_reg    <= req_addr;
        fault_reg <= req_fault;
        instr_reg <= req_fault ? 32'h0 : mem[req_widx[IDX_W-1:0]];
      end
    end
  end

  assign rsp_instr = instr_reg;
  assign rsp_pc    = pc_reg;
  assign rsp_fault = fault_reg;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: one LATENCY=2 and one LATENCY=1 instance, checked
// every cycle against a pending-response model plus literal expectations.
module tb_imem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        flush     [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_instr [2];
  logic [31:0] rsp_pc    [2];
  logic        rsp_fault [2];
  logic        load_en   [2];
  logic [31:0] load_addr [2];
  logic [31:0] load_data [2];

  always #5 clk = ~clk;

  imem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .flush(flush[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_instr(rsp_instr[0]),
    .rsp_pc(rsp_pc[0]), .rsp_fault(rsp_fault[0]),
    .load_en(load_en[0]), .load_addr(load_addr[0]), .load_data(load_data[0])
  );

  imem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .flush(flush[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_instr(rsp_instr[1]),
    .rsp_pc(rsp_pc[1]), .rsp_fault(rsp_fault[1]),
    .load_en(load_en[1]), .load_addr(load_addr[1]), .load_data(load_data[1])
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h, expected %h at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input int d, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %b, expected %b at %0t", name, d, act, exp, $time);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic bit bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
  endfunction

  // Model: at most one pending response per instance, visible from a known cycle on.
  int          cyc = 0;
  bit          pend       [2];
  int          pend_at    [2];
  logic [31:0] pend_pc    [2];
  logic [31:0] pend_instr [2];
  bit          pend_fault [2];
  bit          pend_known [2];
  logic [31:0] mmem   [2][DEPTH];
  bit          mknown [2][DEPTH];

  task automatic model_step(input int d);
    bit exp_valid, exp_ready, hs, acc;
    int idx;
    if (!rst_n) begin
      pend[d] = 1'b0;
      chkb("rst_req_ready", d, req_ready[d], 1'b0);
      chkb("rst_rsp_valid", d, rsp_valid[d], 1'b0);
      chk("rst_rsp_instr", d, rsp_instr[d], 32'h0);
      chk("rst_rsp_pc", d, rsp_pc[d], 32'h0);
      chkb("rst_rsp_fault", d, rsp_fault[d], 1'b0);
      return;
    end
    exp_valid = pend[d] && (cyc >= pend_at[d]);
    hs        = exp_valid && rsp_ready[d];
    exp_ready = !flush[d] && (!pend[d] || hs);
    chkb("req_ready", d, req_ready[d], exp_ready);
    chkb("rsp_valid", d, rsp_valid[d], exp_valid);
    if (exp_valid) begin
      if (pend_known[d]) chk("rsp_instr", d, rsp_instr[d], pend_instr[d]);
      chk("rsp_pc", d, rsp_pc[d], pend_pc[d]);
      chkb("rsp_fault", d, rsp_fault[d], pend_fault[d]);
    end
    if (hs) $display("dut%0d rsp pc=%h instr=%h fault=%0d", d, pend_pc[d], pend_instr[d], pend_fault[d]);
    acc = req_valid[d] && exp_ready;
    if (flush[d] || hs) pend[d] = 1'b0;
    if (acc) begin
      pend[d]       = 1'b1;
      pend_at[d]    = cyc + lat(d);
      pend_pc[d]    = req_addr[d];
      pend_fault[d] = bad_addr(req_addr[d]);
      if (pend_fault[d]) begin
        pend_instr[d] = 32'h0;
        pend_known[d] = 1'b1;
      end else begin
        idx = int'(req_addr[d] >> 2);
        pend_instr[d] = mmem[d][idx];
        pend_known[d] = mknown[d][idx];
      end
    end
    // Load applied after the fetch read: read-before-write on the same word.
    if (load_en[d] && !bad_addr(load_addr[d])) begin
      idx = int'(load_addr[d] >> 2);
      mmem[d][idx]   = load_data[d];
      mknown[d][idx] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all(input logic [31:0] a, input logic [31:0] dt);
    for (int d = 0; d < 2; d++) begin
      load_en[d] = 1'b1; load_addr[d] = a; load_data[d] = dt;
    end
    tick();
    for (int d = 0; d < 2; d++) load_en[d] = 1'b0;
  endtask

  task automatic fetch(input int d, input logic [31:0] a, input logic [31:0] exp_i, input logic exp_f);
    req_valid[d] = 1'b1; req_addr[d] = a; rsp_ready[d] = 1'b1;
    tick();
    req_valid[d] = 1'b0;
    repeat (lat(d) - 1) tick();
    chkb("lit_valid", d, rsp_valid[d], 1'b1);
    chk("lit_instr", d, rsp_instr[d], exp_i);
    chk("lit_pc", d, rsp_pc[d], a);
    chkb("lit_fault", d, rsp_fault[d], exp_f);
    tick();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_addr[d] = '0; flush[d] = 1'b0; rsp_ready[d] = 1'b0;
      load_en[d] = 1'b0; load_addr[d] = '0; load_data[d] = '0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    load_all(32'h0, 32'h11111111);
    load_all(32'h4, 32'h22222222);
    load_all(32'h8, 32'h33333333);
    load_all(32'h2, 32'hDEADBEEF);
    load_all(32'h100, 32'hBAD0BAD0);

    // Basic read at LATENCY=2
    fetch(0, 32'h4, 32'h22222222, 1'b0);

    // Backpressure then handshake with same-cycle acceptance
    req_valid[0] = 1'b1; req_addr[0] = 32'h8; rsp_ready[0] = 1'b0;
    tick();
    req_valid[0] = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chkb("bp_valid", 0, rsp_valid[0], 1'b1);
      chk("bp_instr", 0, rsp_instr[0], 32'h33333333);
      chk("bp_pc", 0, rsp_pc[0], 32'h8);
      chkb("bp_req_ready", 0, req_ready[0], 1'b0);
      tick();
    end
    rsp_ready[0] = 1'b1; req_valid[0] = 1'b1; req_addr[0] = 32'h0;
    #1;
    chkb("bp_overlap_ready", 0, req_ready[0], 1'b1);
    tick();
    req_valid[0] = 1'b0;
    chkb("bp_wait_valid", 0, rsp_valid[0], 1'b0);
    tick();
    chk("bp_new_instr", 0, rsp_instr[0], 32'h11111111);
    chk("bp_new_pc", 0, rsp_pc[0], 32'h0);
    tick();

    // Faults
    fetch(0, 32'h6, 32'h0, 1'b1);
    fetch(0, 32'(4 * DEPTH), 32'h0, 1'b1);

    // Flush in WAIT with a request held across the flush
    req_valid[0] = 1'b1; req_addr[0] = 32'h0; rsp_ready[0] = 1'b1;
    tick();
    req_addr[0] = 32'h4; flush[0] = 1'b1;
    #1;
    chkb("flush_req_ready", 0, req_ready[0], 1'b0);
    tick();
    flush[0] = 1'b0;
    #1;
    chkb("post_flush_ready", 0, req_ready[0], 1'b1);
    chkb("post_flush_valid", 0, rsp_valid[0], 1'b0);
    tick();
    req_valid[0] = 1'b0;
    chkb("flush_wait_valid", 0, rsp_valid[0], 1'b0);
    tick();
    chk("flush_next_instr", 0, rsp_instr[0], 32'h22222222);
    chk("flush_next_pc", 0, rsp_pc[0], 32'h4);
    tick();

    // Flush in RESP without a handshake
    req_valid[0] = 1'b1; req_addr[0] = 32'h8; rsp_ready[0] = 1'b0;
    tick();
    req_valid[0] = 1'b0;
    tick();
    chkb("resp_before_flush", 0, rsp_valid[0], 1'b1);
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    chkb("resp_after_flush", 0, rsp_valid[0], 1'b0);
    rsp_ready[0] = 1'b1;
    tick();

    // LATENCY=1 streaming
    rsp_ready[1] = 1'b1; req_valid[1] = 1'b1; req_addr[1] = 32'h0;
    tick();
    req_addr[1] = 32'h4;
    chk("stream0_instr", 1, rsp_instr[1], 32'h11111111);
    chk("stream0_pc", 1, rsp_pc[1], 32'h0);
    tick();
    req_addr[1] = 32'h8;
    chk("stream1_instr", 1, rsp_instr[1], 32'h22222222);
    chk("stream1_pc", 1, rsp_pc[1], 32'h4);
    tick();
    req_valid[1] = 1'b0;
    chkb("stream2_valid", 1, rsp_valid[1], 1'b1);
    chk("stream2_instr", 1, rsp_instr[1], 32'h33333333);
    tick();
    chkb("stream_end_valid", 1, rsp_valid[1], 1'b0);

    // Read-before-write on the same word
    req_valid[1] = 1'b1; req_addr[1] = 32'h0;
    load_en[1] = 1'b1; load_addr[1] = 32'h0; load_data[1] = 32'hAAAAAAAA;
    tick();
    req_valid[1] = 1'b0; load_en[1] = 1'b0;
    chk("rbw_old_instr", 1, rsp_instr[1], 32'h11111111);
    tick();
    fetch(1, 32'h0, 32'hAAAAAAAA, 1'b0);

    // A load after acceptance does not disturb the in-flight word
    req_valid[0] = 1'b1; req_addr[0] = 32'h4; rsp_ready[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    load_en[0] = 1'b1; load_addr[0] = 32'h4; load_data[0] = 32'h55555555;
    tick();
    load_en[0] = 1'b0;
    chk("inflight_instr", 0, rsp_instr[0], 32'h22222222);
    tick();
    fetch(0, 32'h4, 32'h55555555, 1'b0);

    // Asynchronous reset while a response is held
    req_valid[0] = 1'b1; req_addr[0] = 32'h8; rsp_ready[0] = 1'b0;
    tick();
    req_valid[0] = 1'b0;
    tick();
    chkb("pre_reset_valid", 0, rsp_valid[0], 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chkb("async_rst_valid", 0, rsp_valid[0], 1'b0);
    chkb("async_rst_ready", 0, req_ready[0], 1'b0);
    chk("async_rst_pc", 0, rsp_pc[0], 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    rsp_ready[0] = 1'b1;
    tick();
    fetch(0, 32'h8, 32'h33333333, 1'b0);
    fetch(1, 32'h4, 32'h22222222, 1'b0);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
